// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI channel-voice transmitter with running status and 8N1 serializer
//
// Ports:
//   CLK, RST (sync, active-low), CE (clock enable; all state holds when 0)
//   CMD_VALID/CMD_READY  command handshake
//   CMD_TYPE, CHANNEL, NOTE_NUM, NOTE_VEL, PROGRAM  command fields, sampled at acceptance
//   TX        serial output, idle high
//   BUSY      message in progress
//   BYTE_OUT  byte currently on the wire, BYTE_DV one enabled-cycle strobe at its start bit

module midi_tx #(
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD           = 31250,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_TYPE,
  input  logic [3:0] CHANNEL,
  input  logic [6:0] NOTE_NUM,
  input  logic [6:0] NOTE_VEL,
  input  logic [6:0] PROGRAM,
  output logic       TX,
  output logic       BUSY,
  output logic [7:0] BYTE_OUT,
  output logic       BYTE_DV
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  // The "more bytes?" decision is taken on the last stop-bit cycle, so the
  // next start bit follows with no gap and needs no state of its own.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    bytes_left;
  logic [23:0]   msg;
  logic [7:0]    shreg;
  logic [7:0]    last_status;   // 0 means "none": real status bytes have MSB=1
  logic [1:0]    lat_type;
  logic [3:0]    lat_ch;
  logic [6:0]    lat_d1;
  logic [6:0]    lat_d2;

  logic [7:0]    status;
  logic          skip;
  logic          reserved;
  logic [1:0]    load_cnt;
  logic [23:0]   load_msg;

  always_comb begin
    // 8x note off, 9x note on, Cx program change
    status   = {1'b1, lat_type[1], 1'b0, (lat_type == 2'b01), lat_ch};
    reserved = (lat_type == 2'b11);
    skip     = RUNNING_STATUS && (status == last_status);
    load_cnt = 2'd0;
    load_msg = {status, 1'b0, lat_d1, 1'b0, lat_d2};
    if (skip) begin
      load_msg = {1'b0, lat_d1, 1'b0, lat_d2, 8'h00};
    end
    if (!reserved) begin
      if (lat_type == 2'b10) begin
        load_cnt = skip ? 2'd1 : 2'd2;
      end else begin
        load_cnt = skip ? 2'd2 : 2'd3;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      CMD_READY   <= 1'b0;
      BUSY        <= 1'b0;
      TX          <= 1'b1;
      BYTE_OUT    <= 8'h00;
      BYTE_DV     <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= 3'd0;
      bytes_left  <= 2'd0;
      msg         <= 24'h0;
      shreg       <= 8'h00;
      last_status <= 8'h00;
      lat_type    <= 2'b00;
      lat_ch      <= 4'h0;
      lat_d1      <= 7'h00;
      lat_d2      <= 7'h00;
    end else if (CE) begin
      BYTE_DV <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CMD_READY && CMD_VALID) begin
            lat_type  <= CMD_TYPE;
            lat_ch    <= CHANNEL;
            lat_d1    <= (CMD_TYPE == 2'b10) ? PROGRAM : NOTE_NUM;
            lat_d2    <= NOTE_VEL;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            state     <= S_LOAD;
          end else begin
            CMD_READY <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!skip && !reserved) begin
            last_status <= status;
          end
          if (load_cnt == 2'd0) begin
            state     <= S_IDLE;
            CMD_READY <= 1'b1;
            BUSY      <= 1'b0;
          end else begin
            // first byte goes straight onto the wire; the rest wait in msg
            BYTE_OUT   <= load_msg[23:16];
            BYTE_DV    <= 1'b1;
            msg        <= {load_msg[15:0], 8'h00};
            bytes_left <= load_cnt - 2'd1;
            TX         <= 1'b0;
            div_cnt    <= '0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            TX      <= BYTE_OUT[0];
            shreg   <= {1'b0, BYTE_OUT[7:1]};
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              TX    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              TX      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bytes_left != 2'd0) begin
              bytes_left <= bytes_left - 2'd1;
              BYTE_OUT   <= msg[23:16];
              BYTE_DV    <= 1'b1;
              msg        <= {msg[15:0], 8'h00};
              TX         <= 1'b0;
              state      <= S_START;
            end else begin
              state     <= S_IDLE;
              CMD_READY <= 1'b1;
              BUSY      <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - self-checking bench for midi_tx, running status on and off side by side

module tb_midi_tx;

  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'd0;
  logic [3:0] channel = 4'd0;
  logic [6:0] note_num = 7'd0;
  logic [6:0] note_vel = 7'd0;
  logic [6:0] program_num = 7'd0;

  logic [1:0] ready, tx, busy, dv;
  logic [7:0] bo0, bo1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model, index 0 = running status on, 1 = running status off.
  // Occupancy is described by j = enabled cycles since acceptance.
  bit         m_act[2];
  bit         m_rdy[2];
  int         m_j[2];
  int         m_n[2];
  logic [7:0] m_b[2][3];
  int         m_last[2];
  logic [7:0] m_bo[2];

  logic [7:0] log0[$];
  logic [7:0] log1[$];
  int         lc0[$];

  logic [7:0] exp_rs  [14] = '{8'h90, 8'h45, 8'h64, 8'h45, 8'h64, 8'h83, 8'h46, 8'h32,
                               8'hC0, 8'h7F, 8'h1E, 8'h90, 8'h45, 8'h64};
  logic [7:0] exp_nrs [16] = '{8'h90, 8'h45, 8'h64, 8'h90, 8'h45, 8'h64, 8'h83, 8'h46,
                               8'h32, 8'hC0, 8'h7F, 8'hC0, 8'h1E, 8'h90, 8'h45, 8'h64};

  midi_tx #(.CLK_FREQ(10), .BAUD(1), .RUNNING_STATUS(1'b1)) dut_rs (
    .CLK(clk), .RST(rst), .CE(ce), .CMD_VALID(cmd_valid), .CMD_READY(ready[0]),
    .CMD_TYPE(cmd_type), .CHANNEL(channel), .NOTE_NUM(note_num), .NOTE_VEL(note_vel),
    .PROGRAM(program_num), .TX(tx[0]), .BUSY(busy[0]), .BYTE_OUT(bo0), .BYTE_DV(dv[0])
  );

  midi_tx #(.CLK_FREQ(10), .BAUD(1), .RUNNING_STATUS(1'b0)) dut_nrs (
    .CLK(clk), .RST(rst), .CE(ce), .CMD_VALID(cmd_valid), .CMD_READY(ready[1]),
    .CMD_TYPE(cmd_type), .CHANNEL(channel), .NOTE_NUM(note_num), .NOTE_VEL(note_vel),
    .PROGRAM(program_num), .TX(tx[1]), .BUSY(busy[1]), .BYTE_OUT(bo1), .BYTE_DV(dv[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  task automatic model_accept(input int r);
    logic [7:0] st;
    logic [7:0] q[$];
    bit skip;
    st = (cmd_type == 2'd0) ? 8'h80 : (cmd_type == 2'd1) ? 8'h90 : 8'hC0;
    st = st | {4'h0, channel};
    q = {};
    if (cmd_type != 2'd3) begin
      skip = (r == 0) && (int'(st) == m_last[r]);
      if (!skip) begin
        q.push_back(st);
        m_last[r] = int'(st);
      end
      if (cmd_type == 2'd2) begin
        q.push_back({1'b0, program_num});
      end else begin
        q.push_back({1'b0, note_num});
        q.push_back({1'b0, note_vel});
      end
    end
    m_n[r] = q.size();
    for (int i = 0; i < m_n[r]; i++) m_b[r][i] = q[i];
    m_act[r] = 1'b1;
    m_j[r]   = 0;
    m_rdy[r] = 1'b0;
  endtask

  function automatic bit in_frame(input int r);
    return m_act[r] && (m_j[r] >= 1) && (m_j[r] <= m_n[r] * FRAME);
  endfunction

  function automatic logic exp_tx(input int r);
    int b, pos;
    logic [7:0] byt;
    if (!in_frame(r)) return 1'b1;
    b   = (m_j[r] - 1) / DIV;
    pos = b % 10;
    byt = m_b[r][b / 10];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byt[pos - 1];
  endfunction

  function automatic logic exp_dv(input int r);
    return in_frame(r) && ((m_j[r] - 1) % FRAME == 0);
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (!rst) begin
        m_act[r] = 1'b0;
        m_rdy[r] = 1'b0;
        m_last[r] = -1;
        m_bo[r] = 8'h00;
        m_j[r] = 0;
      end else if (ce) begin
        if (m_act[r]) begin
          m_j[r]++;
          if (m_j[r] == m_n[r] * FRAME + 1) begin
            m_act[r] = 1'b0;
            m_rdy[r] = 1'b1;
          end else if ((m_j[r] - 1) % FRAME == 0) begin
            m_bo[r] = m_b[r][(m_j[r] - 1) / FRAME];
          end
        end else if (m_rdy[r] && cmd_valid) begin
          model_accept(r);
        end else begin
          m_rdy[r] = 1'b1;
        end
      end
    end
  end

  always begin
    logic ce_s, rst_s;
    string sfx;
    @(posedge clk);
    ce_s = ce;
    rst_s = rst;
    cyc++;
    #1;
    for (int r = 0; r < 2; r++) begin
      sfx = (r == 0) ? "rs" : "nrs";
      chk({"tx_", sfx}, 32'(tx[r]), 32'(exp_tx(r)));
      chk({"ready_", sfx}, 32'(ready[r]), 32'(m_rdy[r]));
      chk({"busy_", sfx}, 32'(busy[r]), 32'(m_act[r]));
      chk({"byte_dv_", sfx}, 32'(dv[r]), 32'(exp_dv(r)));
      chk({"byte_out_", sfx}, 32'((r == 0) ? bo0 : bo1), 32'(m_bo[r]));
    end
    if (ce_s && rst_s && dv[0]) begin
      log0.push_back(bo0);
      lc0.push_back(cyc);
    end
    if (ce_s && rst_s && dv[1]) log1.push_back(bo1);
  end

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_rdy[0] && m_rdy[1]) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] a,
                       input logic [6:0] b);
    wait_idle();
    cmd_type = t;
    channel = ch;
    if (t == 2'd2) begin
      program_num = a;
      note_num = 7'($urandom);
      note_vel = 7'($urandom);
    end else begin
      note_num = a;
      note_vel = b;
      program_num = 7'($urandom);
    end
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!m_rdy[0]) break;
    end
    if (m_rdy[0]) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_type = 2'($urandom);
    channel = 4'($urandom);
    note_num = 7'($urandom);
    note_vel = 7'($urandom);
    program_num = 7'($urandom);
  endtask

  task automatic ready_low_len(output int cnt);
    cnt = 1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (ready[0]) break;
      cnt++;
    end
  endtask

  initial begin
    int len;
    bit rnd_ce;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx[0]), 32'd1);
    chk("reset_ready", 32'(ready[0]), 32'd0);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_byte_out", 32'(bo0), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", 32'(ready[0]), 32'd1);

    issue(2'd1, 4'd0, 7'd69, 7'd100);
    ready_low_len(len);
    chk("ready_low_3byte", 32'(len), 32'd301);
    if (lc0.size() >= 3) begin
      chk("dv_spacing_1", 32'(lc0[1] - lc0[0]), 32'd100);
      chk("dv_spacing_2", 32'(lc0[2] - lc0[1]), 32'd100);
    end else begin
      chk("dv_count_first", 32'(lc0.size()), 32'd3);
    end

    issue(2'd1, 4'd0, 7'd69, 7'd100);
    ready_low_len(len);
    chk("ready_low_running", 32'(len), 32'd201);

    issue(2'd0, 4'd3, 7'd70, 7'd50);
    issue(2'd2, 4'd0, 7'd127, 7'd0);
    issue(2'd2, 4'd0, 7'd30, 7'd0);
    issue(2'd3, 4'd0, 7'd1, 7'd2);
    @(posedge clk);
    #1;
    chk("reserved_ready_back", 32'(ready[0]), 32'd1);
    issue(2'd1, 4'd0, 7'd69, 7'd100);
    wait_idle();

    chk("log_rs_len", 32'(log0.size()), 32'd14);
    for (int i = 0; i < 14; i++)
      if (i < log0.size()) chk($sformatf("log_rs_%0d", i), 32'(log0[i]), 32'(exp_rs[i]));
    chk("log_nrs_len", 32'(log1.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < log1.size()) chk($sformatf("log_nrs_%0d", i), 32'(log1[i]), 32'(exp_nrs[i]));

    issue(2'd1, 4'd0, 7'd69, 7'd100);
    repeat (23) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx", 32'(tx[0]), 32'd1);
    chk("abort_ready", 32'(ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    log0.delete();
    issue(2'd1, 4'd0, 7'd69, 7'd100);
    wait_idle();
    chk("resend_len", 32'(log0.size()), 32'd3);
    if (log0.size() > 0) chk("resend_status", 32'(log0[0]), 32'h90);

    issue(2'd1, 4'd0, 7'd69, 7'd100);
    fork
      begin
        repeat (3) @(negedge clk);
        ce = 1'b0;
        repeat (37) @(negedge clk);
        ce = 1'b1;
      end
      begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk);
          #1;
          if (tx[0] == 1'b0) break;
        end
        while (tx[0] == 1'b0 && cnt < 200) begin
          cnt++;
          @(posedge clk);
          #1;
        end
        chk("stalled_start_clocks", 32'(cnt), 32'd47);
      end
    join
    wait_idle();

    rnd_ce = 1'b1;
    fork
      begin
        while (rnd_ce) begin
          @(negedge clk);
          ce = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 1)),
                7'($urandom), 7'($urandom));
        end
        wait_idle();
        rnd_ce = 1'b0;
      end
    join
    @(negedge clk);
    ce = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
